// File: rtl/hex_display_pkg.sv
// hex_display_pkg: constants shared by the multiplexed hex display driver and its glyph decoder.
// Segment vectors are active-low in the order {g,f,e,d,c,b,a}.
package hex_display_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry n is the glyph for nibble n: 0-9, A, b, C, d, E, F.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low seven-segment glyph decode.
module hex_to_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_driver.sv
// hex_display_driver: captures a 16-bit word and time-multiplexes it onto a 4-digit active-low display.
// Define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 is always shown).
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]       r_capture;
  logic [CNT_W-1:0]  r_refresh_cnt;
  logic [1:0]        r_digit;
  logic              r_flag;
  logic [1:0]        r_frames;
  logic [3:0]        r_anode;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic              w_wrap;
  logic              w_frame_end;
  logic              w_new_value;
  logic [3:0]        w_nibble;
  logic [6:0]        w_glyph;
  logic              w_suppress;
  logic [DIGITS-1:0] w_select;

  // load is a single-cycle strobe with no back-pressure: value is taken on every edge where load is high.
  assign w_wrap      = (r_refresh_cnt == CNT_LAST);
  assign w_frame_end = w_wrap && (r_digit == 2'd3);
  assign w_new_value = load && (value != r_capture);
  assign w_nibble    = r_capture[{r_digit, 2'b00} +: 4];
  assign w_select    = ~(DIGITS'(1) << r_digit);

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    w_suppress = 1'b0;
    case (r_digit)
      2'd3:    w_suppress = (r_capture[15:12] == 4'h0);
      2'd2:    w_suppress = (r_capture[15:8] == 8'h00);
      2'd1:    w_suppress = (r_capture[15:4] == 12'h000);
      default: w_suppress = 1'b0;
    endcase
  end
`else
  assign w_suppress = 1'b0;
`endif

  // Scan position free-runs regardless of blank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_digit       <= 2'd0;
    end else if (w_wrap) begin
      r_refresh_cnt <= '0;
      r_digit       <= r_digit + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
    end
  end

  // A differing load restarts the four-frame window and wins over expiry on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_capture <= 16'h0000;
      r_flag    <= 1'b0;
      r_frames  <= 2'd0;
    end else begin
      if (load) begin
        r_capture <= value;
      end
      if (w_new_value) begin
        r_flag   <= 1'b1;
        r_frames <= 2'd0;
      end else if (r_flag && w_frame_end) begin
        if (r_frames == 2'd3) begin
          r_flag <= 1'b0;
        end
        r_frames <= r_frames + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_anode <= 4'b1111;
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
    end else begin
      if (blank || w_suppress) begin
        r_anode <= 4'b1111;
        r_seg   <= SEG_OFF;
      end else begin
        r_anode <= w_select;
        r_seg   <= w_glyph;
      end
      r_dp <= ~(r_flag && (r_digit == 2'd0) && !blank);
    end
  end

  assign anode = r_anode;
  assign seg   = r_seg;
  assign dp    = r_dp;

endmodule

// File: tb/tb_hex_display_driver.sv
// tb_hex_display_driver: vector table plus per-cycle scoreboard against a behavioural display model.
// Honours LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_hex_display_driver;

  localparam int DIV  = 4;
  localparam int SCAN = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  hex_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .blank (blank),
    .anode (anode),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Entry: {anode[12:9], seg[8:2], dp[1], seg_care[0]}
  logic [12:0] exp_q[$];

  logic [15:0] m_capture;
  int          m_tick;
  int          m_frames_left;

  typedef struct {
    logic [15:0]      value;
    logic [3:0][6:0]  seg;
    logic [3:0][3:0]  an;
    logic [3:0]       seg_care;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_capture     = 16'h0000;
    m_tick        = 0;
    m_frames_left = 0;
    exp_q.delete();
  endtask

  // Predict the outputs of the coming edge, advance the model, then compare at the next falling edge.
  task automatic tick(output int shown_digit);
    int          d;
    logic [15:0] upper;
    logic        lz;
    logic [12:0] e;
    d     = m_tick / DIV;
    upper = m_capture >> (4 * d);
    lz    = (d != 0) && (upper == 16'h0000);
`ifndef LEADING_ZERO_BLANK_EN
    lz = 1'b0;
`endif
    if (blank)   e = {4'b1111, 7'b1111111, 1'b1, 1'b1};
    else if (lz) e = {4'b1111, 7'b1111111, 1'b1, 1'b0};
    else         e = {~4'(1 << d), glyph(upper[3:0]), !(m_frames_left > 0 && d == 0), 1'b1};
    exp_q.push_back(e);

    if (load && value != m_capture) begin
      m_capture     = value;
      m_frames_left = 4;
    end else if (m_tick == SCAN - 1 && m_frames_left > 0) begin
      m_frames_left--;
    end
    m_tick = (m_tick + 1) % SCAN;

    @(negedge clk);
    e = exp_q.pop_front();
    check("scan_anode", anode, e[12:9]);
    if (e[0]) check("scan_seg", seg, e[8:2]);
    check("scan_dp", dp, e[1]);
    shown_digit = d;
  endtask

  task automatic run(input int n);
    int d;
    for (int i = 0; i < n; i++) tick(d);
  endtask

  task automatic wait_pos(input int p);
    int d;
    for (int g = 0; g < SCAN && m_tick != p; g++) tick(d);
  endtask

  task automatic do_load(input logic [15:0] v);
    int d;
    value = v;
    load  = 1'b1;
    tick(d);
    load  = 1'b0;
  endtask

  task automatic count_dp_low(input int n, output int lows);
    int d;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      tick(d);
      if (dp === 1'b0) lows++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    int lows;
    int lows2;

    vecs[0] = '{16'h1A2F, {7'h79, 7'h08, 7'h24, 7'h0E}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF};
    vecs[1] = '{16'h3210, {7'h30, 7'h24, 7'h79, 7'h40}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF};
    vecs[2] = '{16'h4567, {7'h19, 7'h12, 7'h02, 7'h78}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF};
    vecs[3] = '{16'h89AB, {7'h00, 7'h10, 7'h08, 7'h03}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF};
    vecs[4] = '{16'hCDEF, {7'h46, 7'h21, 7'h06, 7'h0E}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[5] = '{16'h0005, {7'h7F, 7'h7F, 7'h7F, 7'h12}, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b0001};
`else
    vecs[5] = '{16'h0005, {7'h40, 7'h40, 7'h40, 7'h12}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF};
`endif

    // Reset state, independent of the clock.
    reset = 1'b1;
    load  = 1'b0;
    blank = 1'b0;
    value = 16'h0000;
    #1;
    check("reset_anode", anode, 4'b1111);
    check("reset_seg", seg, 7'b1111111);
    check("reset_dp", dp, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // First edge after release shows digit 0 as "0".
    tick(d);
    check("release_anode", anode, 4'b1110);
    check("release_seg", seg, 7'b1000000);

    // Glyph table: loads land mid-scan and must show on the current digit immediately.
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].value);
      for (int k = 0; k < SCAN; k++) begin
        tick(d);
        check("vec_anode", anode, vecs[i].an[d]);
        if (vecs[i].seg_care[d]) check("vec_seg", seg, vecs[i].seg[d]);
      end
    end

    // Blank mid-scan for 10 cycles; the scan keeps running underneath.
    run(5);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(d);
      check("blank_anode", anode, 4'b1111);
      check("blank_seg", seg, 7'b1111111);
    end
    blank = 1'b0;
    run(20);

    // New-value indicator: four frames of digit 0 after a differing load, none after a repeat.
    run(80);
    wait_pos(SCAN - 1);
    do_load(16'h1234);
    count_dp_low(100, lows);
    check("dp_first_load", lows, 16);
    do_load(16'h1234);
    count_dp_low(100, lows);
    check("dp_repeat_load", lows, 0);

    // Restart mid-window, then a load on the very edge the flag would expire.
    wait_pos(SCAN - 1);
    do_load(16'h1111);
    count_dp_low(31, lows);
    do_load(16'h2222);
    count_dp_low(63, lows2);
    lows += lows2;
    do_load(16'h3333);
    count_dp_low(80, lows2);
    lows += lows2;
    check("dp_restart_total", lows, 40);

    // Asynchronous reset between edges during digit 2 discards capture and flag.
    do_load(16'h5A5A);
    wait_pos(2 * DIV + 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_anode", anode, 4'b1111);
    check("async_reset_seg", seg, 7'b1111111);
    check("async_reset_dp", dp, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("held_reset_anode", anode, 4'b1111);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick(d);
    check("post_reset_anode", anode, 4'b1110);
    check("post_reset_seg", seg, 7'b1000000);
    check("post_reset_dp", dp, 1'b1);
    run(SCAN);

    // Random loads, repeats and blanking.
    for (int i = 0; i < 120; i++) begin
      load  = ($urandom_range(0, 3) == 0);
      value = ($urandom_range(0, 3) == 0) ? m_capture : 16'($urandom_range(0, 65535));
      blank = ($urandom_range(0, 7) == 0);
      tick(d);
    end
    load  = 1'b0;
    blank = 1'b0;
    run(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hex_display_driver.md
HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clk cycles each digit stays selected (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port value  input  16  processor result word (processor_output of the processor top).
REQ-005 SHALL have port load  input  1  capture strobe; value sampled on any rising clk edge with load=1.
REQ-006 SHALL have port blank  input  1  forces all digits dark while high.
REQ-007 SHALL have port anode  output  4  digit selects, active-low, bit n = hex digit n (digit 0 = value[3:0]).
REQ-008 SHALL have port seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}.
REQ-009 SHALL have port dp  output  1  decimal point, active-low, used as "new value" indicator.

Function
REQ-010 SHALL hold a 16-bit capture register; load=1 replaces it with value on the clock edge, otherwise it holds.
REQ-011 SHALL run a refresh counter 0..REFRESH_DIV-1 that wraps to 0; on wrap the 2-bit digit index advances 0->1->2->3->0.
REQ-012 SHALL register anode, seg and dp: pins reflect digit index, capture register and blank as they stood after the previous edge (one-cycle latency).
REQ-013 SHALL drive exactly one anode low (the indexed digit) when not blanked; seg = hex glyph of that nibble (0-9, A, b, C, d, E, F).
REQ-014 SHALL drive anode=4'b1111, seg=7'b1111111, dp=1 while blank=1; refresh counter and digit index keep running.
REQ-015 SHALL set a new-value flag when load=1 and value differs from the capture register; load with an identical value SHALL NOT set it.
REQ-016 SHALL, while the flag is set, drive dp=0 only when digit 0 is selected and not blanked; dp=1 otherwise.
REQ-017 SHALL clear the flag after 4 complete scan frames (digit index returning to 0 four times) following the load; a new differing load SHALL restart the frame count.
REQ-018 SHALL give load priority over flag expiry when both occur on the same edge.
REQ-019 SHALL apply a load arriving mid-digit on the next edge; the currently selected digit shows the new nibble without waiting for a refresh wrap.

Reset
REQ-020 SHALL, while reset=1, force capture=16'h0000, refresh counter=0, digit index=0, flag=0, anode=4'b1111, seg=7'b1111111, dp=1, regardless of clk.
REQ-021 SHALL show digit 0 (glyph "0", anode=4'b1110) on the first clock edge after reset deassertion with blank=0.
REQ-022 SHALL discard any in-progress scan or flag count when reset asserts mid-operation.

Configuration
REQ-023 SHALL, with LEADING_ZERO_BLANK_EN defined, keep anode high for digit n (n=3..1) when nibbles n..3 of the capture register are all zero; digit 0 is never suppressed; without the macro all four digits always display.

Structure
REQ-024 SHALL place DIGITS=4, the active-low 16-entry seg7 glyph table and the segment-off constant in package hex_display_pkg.
REQ-025 SHALL implement the nibble-to-glyph decode as combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out).

Verification (bench uses REFRESH_DIV=4)
REQ-026 SHALL check: reset, release, load value=16'h1A2F -> digits 0..3 show seg 7'b0001110 (F), 7'b0100100 (2), 7'b0001000 (A), 7'b1111001 (1), each for 4 cycles, anode cycling 1110,1101,1011,0111.
REQ-027 SHALL check: load 16'h0005 with LEADING_ZERO_BLANK_EN -> only anode 1110 ever goes low, seg=7'b0010010; without macro digits 1-3 show 7'b1000000.
REQ-028 SHALL check: load 16'h1234 then load 16'h1234 again after flag expiry -> dp low on digit 0 for 4 frames (64 cycles) after the first load only.
REQ-029 SHALL check: blank=1 for 10 cycles mid-scan -> anode=4'b1111, seg=7'b1111111; after release the scan resumes at the index reached by the free-running counter.
REQ-030 SHALL check: reset asserted asynchronously between clk edges during digit 2 -> outputs go to reset values immediately; capture reads 16'h0000 after release.
